// File: rtl/t5_hsch_pkg.sv
// t5_hsch_pkg: shared types and limits for the hart scheduler.
// Hart state encoding plus the legal NHART/HW range.
package t5_hsch_pkg;

    localparam int NHART_MIN = 2;
    localparam int NHART_MAX = 16;
    localparam int NHART_DEF = 4;
    localparam int HW_MAX    = $clog2(NHART_MAX);

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_RUN  = 2'd1,
        H_WAIT = 2'd2
    } hstate_e;

    function automatic bit cfg_ok(int n, int hw, int xlen);
        return (n >= NHART_MIN) && (n <= NHART_MAX)
            && (hw == $clog2(n)) && (xlen >= hw);
    endfunction

endpackage

// File: rtl/t5_hsch_hfifo.sv
// t5_hfifo: in-order FIFO of hart indices for outstanding bus accesses.
// Pointers wrap modulo DEPTH; occupancy counter separates full/empty.
module t5_hfifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rd_q];

    // Advance pointers and occupancy; a pop on empty is dropped
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone defines validity
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/t5_hsch.sv
// t5_hsch: hart scheduler with round-robin fetch selection.
// Tracks IDLE/RUN/WAIT per hart and the order of outstanding accesses.
module t5_hsch
    import t5_hsch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NHART = NHART_DEF,
    parameter int HW    = $clog2(NHART)
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             sena,
    input  logic [NHART-1:0] hena,
    input  logic             xstb,
    input  logic [HW-1:0]    xhart,
    input  logic             dwb_ack,
    output logic [HW-1:0]    fhart,
    output logic             fvld,
    output logic [NHART-1:0] hwait,
    output logic             herr
);

    if (!cfg_ok(NHART, HW, XLEN)) begin : g_cfg_bad
        $error("t5_hsch: illegal XLEN/NHART/HW combination");
    end

    hstate_e       st_q [NHART];
    hstate_e       st_d [NHART];
    logic [HW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] fhart_q, fhart_d;
    logic          fvld_q, fvld_d;
    logic          herr_q, herr_d;

    logic          x_run;
    logic          push_ok;
    logic          pop_ok;
    logic          q_empty;
    logic [HW-1:0] q_head;
    logic          sel_hit;
    logic [HW-1:0] sel_idx;

    // Is the issuing hart currently eligible to own a new access
    always_comb begin
        x_run = 1'b0;
        for (int i = 0; i < NHART; i++) begin
            if (xhart == HW'(i) && st_q[i] == H_RUN) begin
                x_run = 1'b1;
            end
        end
    end

    assign push_ok = xstb && x_run;
    assign pop_ok  = dwb_ack && !q_empty;

    t5_hfifo #(
        .DEPTH (NHART),
        .DW    (HW)
    ) u_fifo (
        .clk_i   (sclk),
        .rst_i   (srst),
        .push_i  (push_ok),
        .wdata_i (xhart),
        .pop_i   (dwb_ack),
        .rdata_o (q_head),
        .empty_o (q_empty)
    );

    // Hart state register
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            for (int i = 0; i < NHART; i++) begin
                st_q[i] <= H_IDLE;
            end
        end else begin
            for (int i = 0; i < NHART; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    // Hart next state; WAIT only leaves on its own ack
    always_comb begin
        for (int i = 0; i < NHART; i++) begin
            st_d[i] = st_q[i];
            unique case (st_q[i])
                H_IDLE: begin
                    if (hena[i]) begin
                        st_d[i] = H_RUN;
                    end
                end
                H_RUN: begin
                    if (push_ok && xhart == HW'(i)) begin
                        st_d[i] = H_WAIT;
                    end else if (!hena[i]) begin
                        st_d[i] = H_IDLE;
                    end
                end
                H_WAIT: begin
                    if (pop_ok && q_head == HW'(i)) begin
                        st_d[i] = hena[i] ? H_RUN : H_IDLE;
                    end
                end
                default: st_d[i] = H_IDLE;
            endcase
        end
    end

    // Blocked flags decoded from registered state
    always_comb begin
        hwait = '0;
        for (int i = 0; i < NHART; i++) begin
            hwait[i] = (st_q[i] == H_WAIT);
        end
    end

    // Circular search for the first RUN hart after ptr
    always_comb begin
        int            idx;
        logic [HW-1:0] cand;
        sel_hit = 1'b0;
        sel_idx = ptr_q;
        idx     = 0;
        cand    = '0;
        for (int k = NHART; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NHART) begin
                idx = idx - NHART;
            end
            cand = HW'(idx);
            if (st_q[cand] == H_RUN) begin
                sel_hit = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Selection outputs only move while the pipeline is enabled
    always_comb begin
        ptr_d   = ptr_q;
        fhart_d = fhart_q;
        fvld_d  = fvld_q;
        if (sena) begin
            fvld_d = sel_hit;
            if (sel_hit) begin
                ptr_d   = sel_idx;
                fhart_d = sel_idx;
            end
        end
    end

    // Sticky error on an ack with nothing outstanding or a stray issue
    always_comb begin
        herr_d = herr_q;
        if ((xstb && !x_run) || (dwb_ack && q_empty)) begin
            herr_d = 1'b1;
        end
    end

    // Selector and error registers
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            ptr_q   <= HW'(NHART - 1);
            fhart_q <= '0;
            fvld_q  <= 1'b0;
            herr_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            fhart_q <= fhart_d;
            fvld_q  <= fvld_d;
            herr_q  <= herr_d;
        end
    end

    assign fhart = fhart_q;
    assign fvld  = fvld_q;
    assign herr  = herr_q;

endmodule

// File: tb/tb_t5_hsch.sv
// tb_t5_hsch: directed and random stimulus for t5_hsch (NHART=4 and 3),
// compared every cycle against a list-based behavioural model.
`timescale 1ns/1ps
module tb_t5_hsch;

    localparam int NI    = 2;
    localparam int S_IDL = 0;
    localparam int S_RUN = 1;
    localparam int S_WT  = 2;

    logic       clk = 1'b0;
    logic       srst;
    logic       sena_a, xstb_a, ack_a;
    logic [3:0] hena_a;
    logic [1:0] xhart_a;
    logic       sena_b, xstb_b, ack_b;
    logic [2:0] hena_b;
    logic [1:0] xhart_b;
    logic [1:0] fh_a, fh_b;
    logic       fv_a, fv_b, he_a, he_b;
    logic [3:0] hw_a;
    logic [2:0] hw_b;
    logic [3:0] h3;

    always #5 clk = ~clk;

    t5_hsch u4 (
        .sclk(clk), .srst(srst), .sena(sena_a), .hena(hena_a),
        .xstb(xstb_a), .xhart(xhart_a), .dwb_ack(ack_a),
        .fhart(fh_a), .fvld(fv_a), .hwait(hw_a), .herr(he_a)
    );

    t5_hsch #(.NHART(3)) u3 (
        .sclk(clk), .srst(srst), .sena(sena_b), .hena(hena_b),
        .xstb(xstb_b), .xhart(xhart_b), .dwb_ack(ack_b),
        .fhart(fh_b), .fvld(fv_b), .hwait(hw_b), .herr(he_b)
    );

    // Behavioural model: per-hart state, outstanding list, pointer
    int mst  [NI][16];
    int mql  [NI][16];
    int mqn  [NI];
    int mptr [NI];
    int mfh  [NI];
    int mfv  [NI];
    int merr [NI];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic int nh(int u);
        return (u == 0) ? 4 : 3;
    endfunction

    task automatic m_reset(int u);
        for (int i = 0; i < 16; i++) mst[u][i] = S_IDL;
        mqn[u]  = 0;
        mptr[u] = nh(u) - 1;
        mfh[u]  = 0;
        mfv[u]  = 0;
        merr[u] = 0;
    endtask

    task automatic m_step(int u, bit se, bit [3:0] hn, bit xs, int xh, bit ak);
        int n = nh(u);
        bit push, pop;
        int ph, sel, c;
        pop  = ak && (mqn[u] > 0);
        ph   = pop ? mql[u][0] : -1;
        push = xs && (xh < n) && (mst[u][xh] == S_RUN);
        if ((ak && !pop) || (xs && !push)) merr[u] = 1;
        if (se) begin
            sel = -1;
            for (int k = 1; k <= n; k++) begin
                c = (mptr[u] + k) % n;
                if (sel < 0 && mst[u][c] == S_RUN) sel = c;
            end
            if (sel >= 0) begin
                mfh[u] = sel; mfv[u] = 1; mptr[u] = sel;
            end else begin
                mfv[u] = 0;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (mst[u][i] == S_IDL) begin
                if (hn[i]) mst[u][i] = S_RUN;
            end else if (mst[u][i] == S_RUN) begin
                if (push && xh == i) mst[u][i] = S_WT;
                else if (!hn[i]) mst[u][i] = S_IDL;
            end else if (i == ph) begin
                mst[u][i] = hn[i] ? S_RUN : S_IDL;
            end
        end
        if (pop) begin
            for (int j = 0; j < 15; j++) mql[u][j] = mql[u][j+1];
            mqn[u] = mqn[u] - 1;
        end
        if (push) begin
            mql[u][mqn[u]] = xh;
            mqn[u] = mqn[u] + 1;
        end
    endtask

    function automatic int mhw(int u);
        int r = 0;
        for (int i = 0; i < nh(u); i++)
            if (mst[u][i] == S_WT) r = r | (1 << i);
        return r;
    endfunction

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    endfunction

    // Model advances on each rising edge; outputs compared 1ns later
    always @(posedge clk) begin
        if (srst) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, sena_a, hena_a, xstb_a, int'(xhart_a), ack_a);
            m_step(1, sena_b, {1'b0, hena_b}, xstb_b, int'(xhart_b), ack_b);
        end
        #1;
        chk("a.fhart", int'(fh_a), mfh[0]);
        chk("a.fvld",  int'(fv_a), mfv[0]);
        chk("a.hwait", int'(hw_a), mhw(0));
        chk("a.herr",  int'(he_a), merr[0]);
        chk("b.fhart", int'(fh_b), mfh[1]);
        chk("b.fvld",  int'(fv_b), mfv[1]);
        chk("b.hwait", int'(hw_b), mhw(1));
        chk("b.herr",  int'(he_b), merr[1]);
    end

    task automatic tk(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic xa(int h);
        xstb_a = 1'b1; xhart_a = 2'(h); tk(); xstb_a = 1'b0;
    endtask

    task automatic xb(int h);
        xstb_b = 1'b1; xhart_b = 2'(h); tk(); xstb_b = 1'b0;
    endtask

    task automatic ackb();
        ack_b = 1'b1; tk(); ack_b = 1'b0;
    endtask

    task automatic acka();
        ack_a = 1'b1; tk(); ack_a = 1'b0;
    endtask

    task automatic rnd_in(int u, output logic se, inout logic [3:0] hn,
                          output logic xs, output logic [1:0] xh,
                          output logic ak);
        int runs [4];
        int nr = 0;
        se = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) hn = 4'($urandom);
        for (int i = 0; i < nh(u); i++)
            if (mst[u][i] == S_RUN) begin runs[nr] = i; nr++; end
        xs = ($urandom_range(0, 2) == 0);
        if (nr > 0 && $urandom_range(0, 19) != 0)
            xh = 2'(runs[$urandom_range(0, nr - 1)]);
        else
            xh = 2'($urandom_range(0, 3));
        ak = ($urandom_range(0, 2) == 0) &&
             (mqn[u] > 0 || $urandom_range(0, 19) == 0);
    endtask

    initial begin
        int e35 [5] = '{0, 1, 2, 3, 0};
        int e36 [3] = '{2, 0, 2};
        srst = 1'b1;
        sena_a = 0; xstb_a = 0; ack_a = 0; hena_a = '0; xhart_a = '0;
        sena_b = 0; xstb_b = 0; ack_b = 0; hena_b = '0; xhart_b = '0;
        tk(2);
        chk("rst.fvld", int'(fv_a), 0);
        chk("rst.fhart", int'(fh_a), 0);
        chk("rst.herr", int'(he_a), 0);
        chk("rst.hwait", int'(hw_a), 0);

        // All harts enabled: round robin from index 0
        srst = 1'b0; hena_a = 4'b1111; sena_a = 1'b1;
        tk();
        chk("rr.fvld0", int'(fv_a), 0);
        for (int i = 0; i < 5; i++) begin
            tk();
            chk("rr.fhart", int'(fh_a), e35[i]);
            chk("rr.fvld", int'(fv_a), 1);
        end

        // Sparse mask alternates; clearing it drops fvld
        hena_a = 4'b0101;
        tk();
        for (int i = 0; i < 3; i++) begin
            tk();
            chk("alt.fhart", int'(fh_a), e36[i]);
        end
        hena_a = 4'b0000;
        tk(2);
        chk("off.fvld", int'(fv_a), 0);
        chk("off.fhart", int'(fh_a), 0);

        // Blocked harts skipped, released in issue order
        hena_a = 4'b1111;
        tk(2);
        xa(1);
        xa(3);
        chk("blk.hwait", int'(hw_a), 4'b1010);
        tk(2);
        chk("blk.skip", int'(fh_a), 2);
        tk();
        chk("blk.skip2", int'(fh_a), 0);
        acka();
        chk("ack1.hwait", int'(hw_a), 4'b1000);
        acka();
        chk("ack2.hwait", int'(hw_a), 4'b0000);
        chk("ack2.herr", int'(he_a), 0);

        // Simultaneous pop of hart 0 and push of hart 2
        xa(0);
        chk("sim.pre", int'(hw_a), 4'b0001);
        ack_a = 1'b1;
        xa(2);
        ack_a = 1'b0;
        chk("sim.hwait", int'(hw_a), 4'b0100);
        acka();
        chk("sim.drain", int'(hw_a), 4'b0000);
        chk("sim.herr0", int'(he_a), 0);
        acka();
        chk("empty.herr", int'(he_a), 1);
        tk(3);
        chk("sticky.herr", int'(he_a), 1);

        // Reset mid-access discards it; first pick is lowest enabled
        xa(1);
        chk("mid.hwait", int'(hw_a), 4'b0010);
        srst = 1'b1; hena_a = 4'b0110;
        #1;
        chk("async.hwait", int'(hw_a), 0);
        chk("async.herr", int'(he_a), 0);
        tk();
        srst = 1'b0; ack_a = 1'b1;
        tk();
        ack_a = 1'b0;
        chk("stale.herr", int'(he_a), 1);
        chk("rel.fvld", int'(fv_a), 0);
        tk();
        chk("rel.fhart", int'(fh_a), 1);
        chk("rel.fvld1", int'(fv_a), 1);

        // Issue from a hart already waiting
        srst = 1'b1; tk(); srst = 1'b0; hena_a = 4'b1111;
        tk();
        xa(2);
        xa(2);
        chk("dup.herr", int'(he_a), 1);
        chk("dup.hwait", int'(hw_a), 4'b0100);

        // Three-hart instance: enable gating and pointer wrap
        hena_a = '0; sena_a = 1'b0;
        srst = 1'b1; tk(); srst = 1'b0;
        hena_b = 3'b111; sena_b = 1'b1;
        tk(2);
        chk("b.f0", int'(fh_b), 0);
        tk();
        chk("b.f1", int'(fh_b), 1);
        sena_b = 1'b0;
        tk();
        chk("b.hold", int'(fh_b), 1);
        chk("b.holdv", int'(fv_b), 1);
        tk();
        chk("b.hold2", int'(fh_b), 1);
        sena_b = 1'b1;
        tk();
        chk("b.f2", int'(fh_b), 2);
        tk();
        chk("b.f3", int'(fh_b), 0);
        for (int r = 0; r < 4; r++) begin
            xb(r % 3);
            chk("b.push", int'(hw_b), 1 << (r % 3));
            ackb();
            chk("b.pop", int'(hw_b), 0);
        end
        xb(1);
        xb(2);
        chk("b.two", int'(hw_b), 3'b110);
        ackb();
        chk("b.ord", int'(hw_b), 3'b100);
        ackb();
        chk("b.done", int'(hw_b), 0);
        chk("b.herr", int'(he_b), 0);

        // Random traffic on both instances with occasional reset
        h3 = 4'b0111;
        for (int c = 0; c < 3000; c++) begin
            srst = ($urandom_range(0, 249) == 0);
            rnd_in(0, sena_a, hena_a, xstb_a, xhart_a, ack_a);
            rnd_in(1, sena_b, h3, xstb_b, xhart_b, ack_b);
            hena_b = h3[2:0];
            tk();
        end
        srst = 1'b0;
        tk(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/t5_hsch.md
T5_HSCH -- requirements
Module: t5_hsch

Interface
REQ-001 Parameter XLEN, default 32; datapath width, used only for consistency checks.
REQ-002 Parameter NHART, default 4; number of hardware threads (harts), legal range 2..16, any integer.
REQ-003 Parameter HW, default $clog2(NHART); width of a hart index.
REQ-004 sclk  in  1  sole clock; all state updates on the rising edge.
REQ-005 srst  in  1  reset, asynchronous, active-high.
REQ-006 sena  in  1  pipeline enable; low freezes the scheduling outputs.
REQ-007 hena  in  NHART  per-hart enable mask; bit i high means hart i may run.
REQ-008 xstb  in  1  a data-bus access was issued by hart xhart this cycle.
REQ-009 xhart  in  HW  hart index that owns xstb.
REQ-010 dwb_ack  in  1  the oldest outstanding data-bus access completed.
REQ-011 fhart  out  HW  registered index of the hart selected to fetch.
REQ-012 fvld  out  1  registered; fhart is a valid selection.
REQ-013 hwait  out  NHART  per-hart flag: hart is blocked on an outstanding access.
REQ-014 herr  out  1  sticky protocol-error flag.

Function
REQ-015 Each hart holds one of three states: IDLE (disabled), RUN (eligible), WAIT (blocked on the data bus).
REQ-016 Transitions: IDLE->RUN when hena[i]=1; RUN->IDLE when hena[i]=0; RUN->WAIT on xstb with xhart=i; WAIT->RUN on dwb_ack popping i with hena[i]=1; WAIT->IDLE on dwb_ack popping i with hena[i]=0.
REQ-017 WAIT ignores hena: a disabled hart stays in WAIT until its ack.
REQ-018 In a cycle with sena=1, the selector chooses the first RUN hart after the last selected index, in circular order (ptr+1 .. ptr+NHART mod NHART).
REQ-019 Selection uses the hart states registered at the start of the cycle; a hart made RUN in cycle t is selectable from cycle t+1.
REQ-020 On a selection, fhart<=selected index, fvld<=1, and ptr<=selected index.
REQ-021 With no RUN hart and sena=1: fvld<=0, and fhart and ptr hold.
REQ-022 With sena=0: fhart, fvld and ptr hold; hart states, the queue and herr still update.
REQ-023 Outstanding accesses sit in an in-order FIFO of hart indices, depth NHART; xstb pushes xhart and dwb_ack pops the head.
REQ-024 Simultaneous push and pop in one cycle: the pop applies to the old head, the push is accepted, and occupancy is unchanged.
REQ-025 The FIFO cannot overflow in legal use, because a hart in WAIT is never selected.
REQ-026 Error: xstb for a hart not in RUN is ignored (no push, no state change) and sets herr.
REQ-027 Error: dwb_ack with the FIFO empty is ignored and sets herr.
REQ-028 The FIFO read and write pointers wrap modulo NHART; full and empty are distinguished by an occupancy counter of width HW+1.
REQ-029 hwait[i]=1 exactly when hart i is in WAIT; it is decoded from registered state.

Reset
REQ-030 While srst=1, asynchronously: all harts IDLE; FIFO empty with pointers at 0; ptr=NHART-1; fhart=0; fvld=0; herr=0.
REQ-031 Reset asserted mid-operation discards all outstanding accesses; a dwb_ack after reset release with the FIFO empty sets herr.
REQ-032 In the first enabled cycle after release, harts with hena=1 enter RUN; the first selection, one cycle later, is the lowest enabled index.

Structure
REQ-033 The hart-state encoding (IDLE/RUN/WAIT) and the NHART/HW limits belong in the shared t5 package.
REQ-034 The in-order index FIFO is one sub-module, t5_hfifo, parametrised by depth and data width; the round-robin selector stays inline.

Verification
REQ-035 Reset, then hena=4'b1111 and sena=1 held -> fvld rises one cycle after the harts enter RUN; fhart sequence 0,1,2,3,0.
REQ-036 hena=4'b0101 -> fhart alternates 0,2,0,2; clearing hena to 0 -> fvld=0 within 2 cycles while fhart holds its last value.
REQ-037 xstb for xhart=1, then xstb for xhart=3, with no acks -> hwait=4'b1010 and harts 1 and 3 are skipped; first dwb_ack -> hart 1 returns to RUN, second dwb_ack -> hart 3 returns to RUN.
REQ-038 dwb_ack and xstb(xhart=2) in the same cycle with hart 0 at the head -> hart 0 goes to RUN, hart 2 goes to WAIT, occupancy unchanged.
REQ-039 dwb_ack with the FIFO empty, or xstb for a WAIT hart -> herr=1, and it stays 1 until srst.
REQ-040 NHART=3, with sena toggled 1,0,1 -> fhart holds during sena=0; the FIFO pointers wrap 2->0 correctly over 4 push/pop rounds.
